// File: rtl/fust_gen.sv
// Functional-unit status table: one row per functional unit, each with its
// own FREE/WAIT/EXEC state machine, producer-tag wakeup from the result bus,
// a registered occupancy count and a sticky dispatch error flag.

// One table row: state, latched fields and wakeup of the two producer tags.
module fust_row #(
  parameter int OP_W  = 4,
  parameter int REG_W = 5,
  parameter int TAG_W = 3
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             i_flush,
  input  logic             i_dis,
  input  logic [OP_W-1:0]  i_op,
  input  logic [REG_W-1:0] i_rd,
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rs2,
  input  logic [TAG_W-1:0] i_t1,
  input  logic [TAG_W-1:0] i_t2,
  input  logic             i_wb_en,
  input  logic [TAG_W-1:0] i_wb_tag,
  input  logic             i_issue,
  input  logic             i_done,
  output logic             o_free,
  output logic             o_exec,
  output logic             o_rdy,
  output logic [OP_W-1:0]  o_op,
  output logic [REG_W-1:0] o_rd,
  output logic [REG_W-1:0] o_rs1,
  output logic [REG_W-1:0] o_rs2,
  output logic [TAG_W-1:0] o_t1,
  output logic [TAG_W-1:0] o_t2
);
  typedef enum logic [1:0] {FREE = 2'd0, WAIT = 2'd1, EXEC = 2'd2} st_t;

  st_t              r_st;
  logic [OP_W-1:0]  r_op;
  logic [REG_W-1:0] r_rd, r_rs1, r_rs2;
  logic [TAG_W-1:0] r_t1, r_t2;
  logic             w_wb, w_hit1, w_hit2, w_byp1, w_byp2, w_rdy;

  // A zero tag never wakes anything: it already means "no dependency".
  assign w_wb   = i_wb_en && (i_wb_tag != '0);
  assign w_hit1 = w_wb && (r_t1 == i_wb_tag);
  assign w_hit2 = w_wb && (r_t2 == i_wb_tag);
  assign w_byp1 = w_wb && (i_t1 == i_wb_tag);
  assign w_byp2 = w_wb && (i_t2 == i_wb_tag);
  assign w_rdy  = (r_st == WAIT) && (r_t1 == '0) && (r_t2 == '0);

  // Row state machine; a row leaving EXEC zeroes its fields so FREE rows read 0.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST || i_flush) begin
      if (!nRST) r_st <= FREE; else r_st <= FREE;
      r_op <= '0; r_rd <= '0; r_rs1 <= '0; r_rs2 <= '0; r_t1 <= '0; r_t2 <= '0;
    end else begin
      case (r_st)
        FREE: if (i_dis) begin
          r_st  <= WAIT;
          r_op  <= i_op;
          r_rd  <= i_rd;
          r_rs1 <= i_rs1;
          r_rs2 <= i_rs2;
          r_t1  <= w_byp1 ? '0 : i_t1;
          r_t2  <= w_byp2 ? '0 : i_t2;
        end
        WAIT: begin
          if (i_issue && w_rdy) r_st <= EXEC;
          if (w_hit1) r_t1 <= '0;
          if (w_hit2) r_t2 <= '0;
        end
        EXEC: if (i_done) begin
          r_st <= FREE;
          r_op <= '0; r_rd <= '0; r_rs1 <= '0; r_rs2 <= '0; r_t1 <= '0; r_t2 <= '0;
        end else begin
          if (w_hit1) r_t1 <= '0;
          if (w_hit2) r_t2 <= '0;
        end
        default: r_st <= FREE;
      endcase
    end
  end

  assign o_free = (r_st == FREE);
  assign o_exec = (r_st == EXEC);
  assign o_rdy  = w_rdy;
  assign o_op   = r_op;
  assign o_rd   = r_rd;
  assign o_rs1  = r_rs1;
  assign o_rs2  = r_rs2;
  assign o_t1   = r_t1;
  assign o_t2   = r_t2;
endmodule

module fust_gen #(
  parameter int NUM_FU = 4,
  parameter int OP_W   = 4,
  parameter int REG_W  = 5,
  parameter int TAG_W  = 3,
  parameter int FU_W   = $clog2(NUM_FU),
  parameter int CNT_W  = $clog2(NUM_FU+1)
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    dis_en,
  input  logic [FU_W-1:0]         dis_fu,
  input  logic [OP_W-1:0]         dis_op,
  input  logic [REG_W-1:0]        dis_rd,
  input  logic [REG_W-1:0]        dis_rs1,
  input  logic [REG_W-1:0]        dis_rs2,
  input  logic [TAG_W-1:0]        dis_t1,
  input  logic [TAG_W-1:0]        dis_t2,
  input  logic                    wb_en,
  input  logic [TAG_W-1:0]        wb_tag,
  input  logic [NUM_FU-1:0]       issue_en,
  input  logic [NUM_FU-1:0]       done,
  input  logic                    flush,
  output logic [NUM_FU-1:0]       dis_ready,
  output logic [NUM_FU-1:0]       busy,
  output logic [NUM_FU-1:0]       rdy,
  output logic [NUM_FU*OP_W-1:0]  op_o,
  output logic [NUM_FU*REG_W-1:0] rd_o,
  output logic [NUM_FU*REG_W-1:0] rs1_o,
  output logic [NUM_FU*REG_W-1:0] rs2_o,
  output logic [NUM_FU*TAG_W-1:0] t1_o,
  output logic [NUM_FU*TAG_W-1:0] t2_o,
  output logic [CNT_W-1:0]        n_busy,
  output logic                    err
);
  logic [NUM_FU-1:0] w_sel, w_free, w_exec;
  logic              w_acc;
  logic [CNT_W-1:0]  w_dn_cnt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;

  genvar g;
  generate
    for (g = 0; g < NUM_FU; g++) begin : g_row
      // Out-of-range dis_fu matches no row, so it is simply never accepted.
      assign w_sel[g] = dis_en && (dis_fu == FU_W'(g));
      fust_row #(.OP_W(OP_W), .REG_W(REG_W), .TAG_W(TAG_W)) u_row (
        .CLK(CLK), .nRST(nRST), .i_flush(flush), .i_dis(w_sel[g]),
        .i_op(dis_op), .i_rd(dis_rd), .i_rs1(dis_rs1), .i_rs2(dis_rs2),
        .i_t1(dis_t1), .i_t2(dis_t2), .i_wb_en(wb_en), .i_wb_tag(wb_tag),
        .i_issue(issue_en[g]), .i_done(done[g]),
        .o_free(w_free[g]), .o_exec(w_exec[g]), .o_rdy(rdy[g]),
        .o_op(op_o[g*OP_W +: OP_W]), .o_rd(rd_o[g*REG_W +: REG_W]),
        .o_rs1(rs1_o[g*REG_W +: REG_W]), .o_rs2(rs2_o[g*REG_W +: REG_W]),
        .o_t1(t1_o[g*TAG_W +: TAG_W]), .o_t2(t2_o[g*TAG_W +: TAG_W]));
    end
  endgenerate

  // Accepted dispatch needs the registered FREE state; count rows leaving EXEC.
  always_comb begin
    w_acc    = |(w_sel & w_free);
    w_dn_cnt = '0;
    for (int i = 0; i < NUM_FU; i++) w_dn_cnt = w_dn_cnt + CNT_W'(w_exec[i] & done[i]);
  end

  // Occupancy counter and sticky error; flush clears both.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (flush) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(w_acc) - w_dn_cnt;
      if (dis_en && !w_acc) r_err <= 1'b1;
    end
  end

  assign dis_ready = w_free;
  assign busy      = ~w_free;
  assign n_busy    = r_cnt;
  assign err       = r_err;
endmodule

// File: tb/tb_fust_gen.sv
// Directed bench for fust_gen: a 4-row table for the main scenarios and a
// 3-row table so an out-of-range row index is expressible.
module tb_fust_gen;
  logic        CLK, nRST;
  logic        dis_en, wb_en, flush;
  logic [1:0]  dis_fu;
  logic [3:0]  dis_op;
  logic [4:0]  dis_rd, dis_rs1, dis_rs2;
  logic [2:0]  dis_t1, dis_t2, wb_tag;
  logic [3:0]  issue_en, done;
  logic [3:0]  dis_ready, busy, rdy;
  logic [15:0] op_o;
  logic [19:0] rd_o, rs1_o, rs2_o;
  logic [11:0] t1_o, t2_o;
  logic [2:0]  n_busy;
  logic        err;

  // small 3-row instance
  logic        dis_en3;
  logic [1:0]  dis_fu3;
  logic [2:0]  dr3, busy3, rdy3;
  logic [11:0] op3;
  logic [14:0] rd3, rs13, rs23;
  logic [8:0]  t13, t23;
  logic [1:0]  nb3;
  logic        err3;

  int errors = 0;
  int checks = 0;

  fust_gen dut (
    .CLK(CLK), .nRST(nRST), .dis_en(dis_en), .dis_fu(dis_fu), .dis_op(dis_op),
    .dis_rd(dis_rd), .dis_rs1(dis_rs1), .dis_rs2(dis_rs2), .dis_t1(dis_t1),
    .dis_t2(dis_t2), .wb_en(wb_en), .wb_tag(wb_tag), .issue_en(issue_en),
    .done(done), .flush(flush), .dis_ready(dis_ready), .busy(busy), .rdy(rdy),
    .op_o(op_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .t1_o(t1_o),
    .t2_o(t2_o), .n_busy(n_busy), .err(err));

  fust_gen #(.NUM_FU(3)) dut3 (
    .CLK(CLK), .nRST(nRST), .dis_en(dis_en3), .dis_fu(dis_fu3), .dis_op(4'd1),
    .dis_rd(5'd0), .dis_rs1(5'd0), .dis_rs2(5'd0), .dis_t1(3'd0),
    .dis_t2(3'd0), .wb_en(1'b0), .wb_tag(3'd0), .issue_en(3'd0),
    .done(3'd0), .flush(1'b0), .dis_ready(dr3), .busy(busy3), .rdy(rdy3),
    .op_o(op3), .rd_o(rd3), .rs1_o(rs13), .rs2_o(rs23), .t1_o(t13),
    .t2_o(t23), .n_busy(nb3), .err(err3));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic dispatch(input logic [1:0] fu, input logic [3:0] op, input logic [4:0] rd,
                          input logic [2:0] t1, input logic [2:0] t2);
    dis_en = 1'b1; dis_fu = fu; dis_op = op; dis_rd = rd;
    dis_rs1 = rd + 5'd1; dis_rs2 = rd + 5'd2; dis_t1 = t1; dis_t2 = t2;
  endtask

  task automatic idle();
    dis_en = 1'b0; dis_fu = '0; dis_op = '0; dis_rd = '0; dis_rs1 = '0; dis_rs2 = '0;
    dis_t1 = '0; dis_t2 = '0; wb_en = 1'b0; wb_tag = '0; issue_en = '0; done = '0;
    flush = 1'b0; dis_en3 = 1'b0; dis_fu3 = '0;
  endtask

  initial begin
    nRST = 1'b0;
    idle();
    #3;
    chk("rst_dis_ready", dis_ready, 4'b1111);
    chk("rst_busy", busy, 4'b0000);
    chk("rst_rdy", rdy, 4'b0000);
    chk("rst_n_busy", n_busy, 3'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_op", op_o, 16'h0);
    #4 nRST = 1'b1;
    step();

    // dispatch row 2, no dependencies
    dispatch(2'd2, 4'd5, 5'd3, 3'd0, 3'd0); step(); idle();
    chk("d2_busy", busy, 4'b0100);
    chk("d2_rdy", rdy, 4'b0100);
    chk("d2_n_busy", n_busy, 3'd1);
    chk("d2_op", op_o[8 +: 4], 4'd5);
    chk("d2_rd", rd_o[10 +: 5], 5'd3);
    chk("d2_rs2", rs2_o[10 +: 5], 5'd5);
    chk("d2_dis_ready", dis_ready, 4'b1011);

    // row 1 waits on tags 4 and 6
    dispatch(2'd1, 4'd7, 5'd8, 3'd4, 3'd6); step(); idle();
    chk("d1_rdy", rdy, 4'b0100);
    chk("d1_t1", t1_o[3 +: 3], 3'd4);
    chk("d1_n_busy", n_busy, 3'd2);
    wb_en = 1'b1; wb_tag = 3'd4; step(); idle();
    chk("wb4_rdy1", rdy[1], 1'b0);
    chk("wb4_t1", t1_o[3 +: 3], 3'd0);
    chk("wb4_t2", t2_o[3 +: 3], 3'd6);
    wb_en = 1'b1; wb_tag = 3'd0; step(); idle();
    chk("wb0_t2", t2_o[3 +: 3], 3'd6);
    wb_en = 1'b1; wb_tag = 3'd6; step(); idle();
    chk("wb6_rdy1", rdy[1], 1'b1);
    chk("wb6_t12", {t1_o[3 +: 3], t2_o[3 +: 3]}, 6'd0);

    // bypass: row 0 dispatched with t1=3 while tag 3 is broadcast
    dispatch(2'd0, 4'd2, 5'd1, 3'd3, 3'd0); wb_en = 1'b1; wb_tag = 3'd3; step(); idle();
    chk("byp_t1", t1_o[0 +: 3], 3'd0);
    chk("byp_rdy", rdy, 4'b0111);
    chk("byp_n_busy", n_busy, 3'd3);

    // row 3 not ready; issue is ignored
    dispatch(2'd3, 4'd3, 5'd9, 3'd5, 3'd0); step(); idle();
    chk("d3_n_busy", n_busy, 3'd4);
    issue_en = 4'b1000; step(); idle();
    chk("iss_nr_rdy", rdy, 4'b0111);
    chk("iss_nr_busy", busy, 4'b1111);
    wb_en = 1'b1; wb_tag = 3'd5; step(); idle();
    chk("wb5_rdy", rdy, 4'b1111);
    // issue ready row 2, then complete it
    issue_en = 4'b0100; step(); idle();
    chk("iss2_rdy", rdy, 4'b1011);
    chk("iss2_busy", busy, 4'b1111);
    done = 4'b0100; step(); idle();
    chk("dn2_busy", busy, 4'b1011);
    chk("dn2_dis_ready", dis_ready, 4'b0100);
    chk("dn2_n_busy", n_busy, 3'd3);
    chk("dn2_op", op_o[8 +: 4], 4'd0);
    done = 4'b0010; step(); idle();
    chk("dnwait_busy", busy, 4'b1011);
    chk("dnwait_rdy1", rdy[1], 1'b1);
    chk("dnwait_err", err, 1'b0);

    // dispatch to busy row 1
    dispatch(2'd1, 4'd9, 5'd0, 3'd0, 3'd0); step(); idle();
    chk("dbusy_err", err, 1'b1);
    chk("dbusy_op", op_o[4 +: 4], 4'd7);
    chk("dbusy_n_busy", n_busy, 3'd3);
    // out-of-range row on the 3-row table
    dis_en3 = 1'b1; dis_fu3 = 2'd3; step(); idle();
    chk("oor_err", err3, 1'b1);
    chk("oor_busy", busy3, 3'b000);
    chk("oor_n_busy", nb3, 2'd0);
    // flush
    flush = 1'b1; dispatch(2'd2, 4'd1, 5'd1, 3'd0, 3'd0); step(); idle();
    chk("fl_busy", busy, 4'b0000);
    chk("fl_dis_ready", dis_ready, 4'b1111);
    chk("fl_n_busy", n_busy, 3'd0);
    chk("fl_err", err, 1'b0);
    chk("fl_fields", {op_o, t1_o, rd_o}, 48'h0);

    // fill all rows, run them all, then done[0] with dispatch to busy row 1
    for (int i = 0; i < 4; i++) begin
      dispatch(2'(i), 4'(i + 1), 5'(i), 3'd0, 3'd0); step(); idle();
    end
    chk("fill_n_busy", n_busy, 3'd4);
    issue_en = 4'b1111; step(); idle();
    chk("run_rdy", rdy, 4'b0000);
    done = 4'b0001; dispatch(2'd1, 4'd11, 5'd0, 3'd0, 3'd0); step(); idle();
    chk("dd_n_busy", n_busy, 3'd3);
    chk("dd_err", err, 1'b1);
    chk("dd_dis_ready", dis_ready, 4'b0001);
    chk("dd_op1", op_o[4 +: 4], 4'd2);
    dispatch(2'd0, 4'd10, 5'd4, 3'd0, 3'd0); step(); idle();
    chk("re0_busy", busy, 4'b1111);
    chk("re0_n_busy", n_busy, 3'd4);
    chk("re0_op", op_o[0 +: 4], 4'd10);

    // net-zero count: row 2 finishes while row 0... first free row 3, then swap
    done = 4'b1000; step(); idle();
    chk("dn3_n_busy", n_busy, 3'd3);
    done = 4'b0100; dispatch(2'd3, 4'd6, 5'd2, 3'd0, 3'd0); step(); idle();
    chk("net0_n_busy", n_busy, 3'd3);
    chk("net0_busy", busy, 4'b1011);

    // asynchronous reset mid-operation
    #2 nRST = 1'b0; #1;
    chk("arst_busy", busy, 4'b0000);
    chk("arst_n_busy", n_busy, 3'd0);
    chk("arst_err", err, 1'b0);
    chk("arst_op", op_o, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fust_gen.md
# fust_gen

Parametrised functional-unit status table for the tensor-core scoreboard. It tracks, per functional unit, whether the unit is occupied, the operation dispatched to it, its destination and source registers, and the producer tags of its source operands. Writeback tags broadcast from the result bus clear those producer tags, and the table reports per-unit operand readiness to the issue logic. It generalises the scalar status table to `NUM_FU` units, configurable field widths, a per-row state machine, wakeup bypass, occupancy count and error reporting.

## Interface
- `NUM_FU`, 4: number of functional-unit rows; must be ≥ 2.
- `OP_W`, 4: opcode field width.
- `REG_W`, 5: register index width.
- `TAG_W`, 3: producer tag width; tag 0 means no dependency.
- `FU_W`, `$clog2(NUM_FU)`: row index width (derived).
- `CNT_W`, `$clog2(NUM_FU+1)`: occupancy count width (derived).

- `CLK`  in  1  clock; all state updates on the rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `dis_en`  in  1  dispatch request.
- `dis_fu`  in  FU_W  target row.
- `dis_op`  in  OP_W  opcode.
- `dis_rd`, `dis_rs1`, `dis_rs2`  in  REG_W each  destination and source registers.
- `dis_t1`, `dis_t2`  in  TAG_W each  source producer tags.
- `wb_en`  in  1  writeback broadcast valid.
- `wb_tag`  in  TAG_W  tag being written back.
- `issue_en`  in  NUM_FU  per-row issue grant.
- `done`  in  NUM_FU  per-row execution complete.
- `flush`  in  1  synchronous pipeline flush.
- `dis_ready`  out  NUM_FU  row is FREE.
- `busy`  out  NUM_FU  row is not FREE.
- `rdy`  out  NUM_FU  row is WAIT and both tags are 0.
- `op_o`  out  NUM_FU*OP_W  packed opcodes; row i is at `[i*OP_W +: OP_W]`.
- `rd_o`, `rs1_o`, `rs2_o`  out  NUM_FU*REG_W  packed registers.
- `t1_o`, `t2_o`  out  NUM_FU*TAG_W  packed tags.
- `n_busy`  out  CNT_W  count of non-FREE rows.
- `err`  out  1  sticky protocol error.

## Operation
- Each row has a 3-state machine: FREE, WAIT and EXEC.
  - FREE → WAIT on `dis_en && dis_fu==i`. The row latches all fields.
  - WAIT → EXEC on `issue_en[i] && rdy[i]`. `issue_en[i]` without `rdy[i]` is ignored.
  - EXEC → FREE on `done[i]`. `done` in FREE or WAIT is ignored.
- Wakeup applies to all non-FREE rows. When `wb_en && wb_tag!=0`, any `t1` or `t2` equal to `wb_tag` is cleared to 0. `wb_en` with `wb_tag==0` has no effect.
- Dispatch bypass: if the same-cycle `wb_en`/`wb_tag` matches `dis_t1` or `dis_t2`, that field is stored as 0.
- Dispatch to a non-FREE row: the row is unchanged and `err` is set.
- Dispatch with `dis_fu ≥ NUM_FU`: dropped and `err` is set.
- `flush`: every row goes to FREE, all fields are zeroed, and `err` is cleared. Flush overrides every other input in that cycle.
- Same-row priority when not flushing: done > issue > dispatch. Dispatch is gated on the registered FREE state, so a row freed by `done` in cycle k accepts dispatch only from cycle k+1. Dispatch into a row still in EXEC sets `err`.
- Fields of FREE rows hold 0.
- `n_busy` is a registered counter:
  - +1 per accepted dispatch and −1 per EXEC→FREE; both may occur in one cycle (different rows) for a net 0.
  - It never wraps: its range is 0..NUM_FU.
  - Flush sets it to 0.

## Timing
- Reset (`nRST` low, asynchronous): all rows FREE with zero fields; `dis_ready` all 1; `busy`, `rdy`, `n_busy` and `err` at 0; all packed outputs 0. Reset mid-operation discards all rows immediately.
- All state is registered. `dis_ready`, `busy` and `rdy` decode combinationally from registered state; no input-to-output combinational path exists.
- Dispatch at edge k: `busy` rises after edge k. `rdy` rises in the same cycle if both stored tags are 0, including tags cleared by bypass.
- Writeback at edge k: tags clear after edge k, so `rdy` can assert in the cycle after the broadcast.
- Issue at edge k: `rdy` falls after k.
- Done at edge k: `dis_ready` rises after k.

## Test plan
- Reset, then dispatch row 2 with op=5, rd=3, t1=0, t2=0 → after one edge `busy=0100`, `rdy=0100`, `n_busy=1`, `op_o` row 2 = 5.
- Dispatch row 1 with t1=4, t2=6; broadcast wb_tag=4, then wb_tag=6 → `rdy[1]` stays 0 after the first broadcast and is 1 after the second; `t1_o`/`t2_o` row 1 are both 0.
- Dispatch row 0 with t1=3 while the same cycle carries wb_en, wb_tag=3 → stored t1=0 and `rdy[0]=1` the next cycle.
- Issue a non-ready row → no change; issue a ready row, then `done` → WAIT→EXEC→FREE, and `n_busy` returns to its previous value.
- Dispatch to a busy row, and dispatch with dis_fu=NUM_FU → row unchanged and `err=1`; a subsequent `flush` → all rows FREE, `n_busy=0`, `err=0`.
- Fill all rows, then assert `done[0]` and dispatch row 1 (busy) in the same cycle → `n_busy=NUM_FU−1`, `err=1`, and row 0 accepts dispatch on the next cycle.
